// File: rtl/led_mode_ctrl.sv
// Pushbutton-driven mode controller for the 6-LED display: debounced keys select
// BLINK / BREATHE / CHASE / OFF and pause/resume the running pattern.
module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYC   = 250000,
  parameter int unsigned TICK_CYC       = 27000,
  parameter int unsigned BLINK_TICKS    = 250,
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key,
  output logic [5:0] led,
  output logic [1:0] mode,
  output logic       pause
);

  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned TK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned ST_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_CYC - 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  logic [1:0]            w_key_raw;
  logic [1:0]            r_key_meta;
  logic [1:0]            r_key_sync;
  logic [1:0]            r_key_stable;
  logic [1:0]            r_press;
  logic [1:0][DB_W-1:0]  r_db_cnt;

  mode_e                 r_mode,     w_mode;
  logic                  r_pause,    w_pause;
  logic [TK_W-1:0]       r_presc,    w_presc;
  logic [ST_W-1:0]       r_step_cnt, w_step_cnt;
  logic                  r_phase,    w_phase;
  logic [7:0]            r_duty,     w_duty;
  logic                  r_dir_down, w_dir_down;
  logic [5:0]            r_chase,    w_chase;
  logic [7:0]            r_pwm,      w_pwm;
  logic [5:0]            r_led;
  logic [5:0]            w_pattern;
  logic                  w_tick;
  logic                  w_step;

  // Key levels normalised so that 1 always means "pressed".
  assign w_key_raw = key ^ {2{KEY_ACTIVE_LOW}};

  // Synchronise and debounce both keys; a confirmed press yields a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta   <= 2'b00;
      r_key_sync   <= 2'b00;
      r_key_stable <= 2'b00;
      r_press      <= 2'b00;
      r_db_cnt     <= '0;
    end else begin
      r_key_meta <= w_key_raw;
      r_key_sync <= r_key_meta;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_key_sync[i] != r_key_stable[i]) begin
          if (r_db_cnt[i] == DB_MAX) begin
            r_key_stable[i] <= r_key_sync[i];
            r_db_cnt[i]     <= '0;
            r_press[i]      <= r_key_sync[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Mode/pause state and pattern generator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= MODE_BLINK;
      r_pause    <= 1'b0;
      r_presc    <= '0;
      r_step_cnt <= '0;
      r_phase    <= 1'b0;
      r_duty     <= 8'd0;
      r_dir_down <= 1'b0;
      r_chase    <= 6'b000001;
      r_pwm      <= 8'd0;
      r_led      <= {6{LED_ACTIVE_LOW}};
    end else begin
      r_mode     <= w_mode;
      r_pause    <= w_pause;
      r_presc    <= w_presc;
      r_step_cnt <= w_step_cnt;
      r_phase    <= w_phase;
      r_duty     <= w_duty;
      r_dir_down <= w_dir_down;
      r_chase    <= w_chase;
      r_pwm      <= w_pwm;
      r_led      <= w_pattern ^ {6{LED_ACTIVE_LOW}};
    end
  end

  // Next-state for ticks, patterns and mode; the LED register follows the next pattern.
  always_comb begin
    w_mode     = r_mode;
    w_pause    = r_pause ^ r_press[1];
    w_presc    = r_presc;
    w_step_cnt = r_step_cnt;
    w_phase    = r_phase;
    w_duty     = r_duty;
    w_dir_down = r_dir_down;
    w_chase    = r_chase;
    w_pwm      = r_pwm + 8'd1;
    w_tick     = 1'b0;
    w_step     = 1'b0;
    w_pattern  = 6'b000000;

    if (!r_pause) begin
      if (r_presc == TK_MAX) begin
        w_presc = '0;
        w_tick  = 1'b1;
      end else begin
        w_presc = r_presc + TK_W'(1);
      end
    end else begin
      w_presc = r_presc;
    end

    if (w_tick) begin
      if (r_step_cnt == ST_MAX) begin
        w_step_cnt = '0;
        w_step     = 1'b1;
      end else begin
        w_step_cnt = r_step_cnt + ST_W'(1);
      end
    end else begin
      w_step_cnt = r_step_cnt;
    end

    case (r_mode)
      MODE_BLINK: begin
        if (w_step) w_phase = ~r_phase;
        else        w_phase = r_phase;
      end
      MODE_BREATHE: begin
        // Triangle sweep: 255 turns down toward 254, 0 turns up toward 1.
        if (w_tick) begin
          if (!r_dir_down) begin
            if (r_duty == 8'd255) begin
              w_dir_down = 1'b1;
              w_duty     = 8'd254;
            end else begin
              w_duty = r_duty + 8'd1;
            end
          end else begin
            if (r_duty == 8'd0) begin
              w_dir_down = 1'b0;
              w_duty     = 8'd1;
            end else begin
              w_duty = r_duty - 8'd1;
            end
          end
        end else begin
          w_duty = r_duty;
        end
      end
      MODE_CHASE: begin
        if (w_step) w_chase = {r_chase[4:0], r_chase[5]};
        else        w_chase = r_chase;
      end
      default: begin
        w_chase = r_chase;
      end
    endcase

    if (r_press[0]) begin
      w_mode     = mode_e'(r_mode + 2'd1);
      w_presc    = '0;
      w_step_cnt = '0;
      w_phase    = 1'b0;
      w_duty     = 8'd0;
      w_dir_down = 1'b0;
      w_chase    = 6'b000001;
    end else begin
      w_mode = r_mode;
    end

    case (w_mode)
      MODE_BLINK:   w_pattern = {6{w_phase}};
      MODE_BREATHE: w_pattern = {6{(w_pwm < w_duty)}};
      MODE_CHASE:   w_pattern = w_chase;
      MODE_OFF:     w_pattern = 6'b000000;
      default:      w_pattern = 6'b000000;
    endcase
  end

  assign led   = r_led;
  assign mode  = r_mode;
  assign pause = r_pause;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl with short debounce/tick parameters;
// expectations are queued as stimulus is driven and popped as cycles elapse.
module tb_led_mode_ctrl;

  typedef struct {
    logic [1:0] mode;
    logic       pause;
    logic [5:0] led;
    bit         led_v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [5:0] led;
  logic [1:0] mode;
  logic       pause;

  exp_t       sb[$];
  int         cnt_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [1:0] exp_mode = 2'd0;
  logic       exp_pause = 1'b0;

  led_mode_ctrl #(
    .DEBOUNCE_CYC(4), .TICK_CYC(4), .BLINK_TICKS(2),
    .KEY_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key(key), .led(led), .mode(mode), .pause(pause)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic exp_t mk(input logic [5:0] l, input bit v);
    exp_t e;
    e.mode = exp_mode; e.pause = exp_pause; e.led = l; e.led_v = v;
    return e;
  endfunction

  // Press the keys in mask (held 7 edges); mode/pause must change on exactly the 7th edge.
  task automatic press(input logic [1:0] mask);
    exp_t e;
    key = ~mask;
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) begin
        if (mask[0]) exp_mode = exp_mode + 2'd1;
        if (mask[1]) exp_pause = ~exp_pause;
      end
      sb.push_back(mk(6'h00, 1'b0));
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || pause !== e.pause) begin
        n_errors++;
        $display("FAIL press_latency edge %0d: mode=%0d pause=%b, expected mode=%0d pause=%b",
                 i, mode, pause, e.mode, e.pause);
      end
    end
    key = 2'b11;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (3) step();
    n_checks++;
    if (mode !== 2'd0 || pause !== 1'b0 || led !== 6'h3F) begin
      n_errors++;
      $display("FAIL reset_state: mode=%0d pause=%b led=%h, expected 0 0 3f", mode, pause, led);
    end
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 40; k++) sb.push_back(mk(((k / 8) % 2) ? 6'h00 : 6'h3F, 1'b1));
    for (int k = 1; k <= 40; k++) begin
      step();
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || pause !== e.pause || led !== e.led) begin
        n_errors++;
        $display("FAIL blink cyc=%0d: mode=%0d pause=%b led=%h, expected mode=%0d pause=%b led=%h",
                 cyc, mode, pause, led, e.mode, e.pause, e.led);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    key = 2'b10;
    for (int i = 1; i <= 13; i++) sb.push_back(mk(6'h00, 1'b0));
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i == 3) key = 2'b11;
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || pause !== e.pause) begin
        n_errors++;
        $display("FAIL glitch step %0d: mode=%0d pause=%b, expected mode=%0d pause=%b",
                 i, mode, pause, e.mode, e.pause);
      end
    end
    key = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      if (i == 7) exp_mode = exp_mode + 2'd1;
      sb.push_back(mk(6'h00, 1'b0));
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) key = 2'b11;
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || pause !== e.pause) begin
        n_errors++;
        $display("FAIL long_press step %0d: mode=%0d pause=%b, expected mode=%0d pause=%b",
                 i, mode, pause, e.mode, e.pause);
      end
    end
  endtask

  task automatic test_chase();
    exp_t e;
    logic [5:0] pat;
    press(2'b01);
    for (int k = 0; k <= 55; k++) begin
      pat = 6'd1 << ((k / 8) % 6);
      sb.push_back(mk(~pat, 1'b1));
    end
    for (int k = 0; k <= 55; k++) begin
      if (k > 0) step();
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || led !== e.led) begin
        n_errors++;
        $display("FAIL chase k=%0d: mode=%0d led=%h, expected mode=%0d led=%h", k, mode, led, e.mode, e.led);
      end
    end
    press(2'b01);
    for (int k = 0; k <= 11; k++) sb.push_back(mk(6'h3F, 1'b1));
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) step();
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || led !== e.led) begin
        n_errors++;
        $display("FAIL off k=%0d: mode=%0d led=%h, expected mode=%0d led=%h", k, mode, led, e.mode, e.led);
      end
    end
    press(2'b01);
    for (int k = 0; k <= 9; k++) sb.push_back(mk((k < 8) ? 6'h3F : 6'h00, 1'b1));
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) step();
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || led !== e.led) begin
        n_errors++;
        $display("FAIL blink_reinit k=%0d: mode=%0d led=%h, expected mode=%0d led=%h", k, mode, led, e.mode, e.led);
      end
    end
  endtask

  task automatic test_breathe();
    int m, r, lit, want;
    press(2'b01);
    m = cyc;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_checks++;
      if (led !== 6'h3F) begin
        n_errors++;
        $display("FAIL breathe_duty0 k=%0d: led=%h, expected 3f", k, led);
      end
    end
    while (cyc < m + 249) step();
    press(2'b10);               // frozen after 64 ticks
    repeat (10) step();
    cnt_q.push_back(64);
    lit = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led == 6'h00) lit++;
    end
    want = cnt_q.pop_front(); n_checks++;
    if (lit !== want) begin
      n_errors++;
      $display("FAIL breathe_duty64: lit %0d of 256, expected %0d", lit, want);
    end
    press(2'b10);
    r = cyc;
    while (cyc < r + 937) step();
    press(2'b10);               // frozen after 300 ticks total: duty 210 on the way down
    repeat (10) step();
    cnt_q.push_back(210);
    lit = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led == 6'h00) lit++;
    end
    want = cnt_q.pop_front(); n_checks++;
    if (lit !== want) begin
      n_errors++;
      $display("FAIL breathe_duty210: lit %0d of 256, expected %0d", lit, want);
    end
  endtask

  task automatic test_pause();
    exp_t e;
    logic [5:0] pat;
    press(2'b10);
    repeat (10) step();
    press(2'b01);
    for (int k = 0; k <= 20; k++) begin
      pat = 6'd1 << ((k / 8) % 6);
      sb.push_back(mk(~pat, 1'b1));
    end
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) step();
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || led !== e.led) begin
        n_errors++;
        $display("FAIL chase_run k=%0d: mode=%0d led=%h, expected mode=%0d led=%h", k, mode, led, e.mode, e.led);
      end
    end
    press(2'b10);
    pat = 6'b001000;
    for (int k = 1; k <= 120; k++) sb.push_back(mk(~pat, 1'b1));
    for (int k = 1; k <= 120; k++) begin
      step();
      e = sb.pop_front(); n_checks++;
      if (pause !== e.pause || led !== e.led) begin
        n_errors++;
        $display("FAIL chase_frozen k=%0d: pause=%b led=%h, expected pause=%b led=%h", k, pause, led, e.pause, e.led);
      end
    end
    press(2'b10);
    for (int k = 0; k <= 40; k++) begin
      pat = 6'd1 << (((27 + k) / 8) % 6);
      sb.push_back(mk(~pat, 1'b1));
    end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      e = sb.pop_front(); n_checks++;
      if (pause !== e.pause || led !== e.led) begin
        n_errors++;
        $display("FAIL chase_resume k=%0d: pause=%b led=%h, expected pause=%b led=%h", k, pause, led, e.pause, e.led);
      end
    end
  endtask

  task automatic test_both_and_reset();
    exp_t e;
    press(2'b11);
    repeat (10) step();
    press(2'b11);
    repeat (10) step();
    press(2'b01);
    repeat (10) step();
    press(2'b10);
    repeat (20) step();
    #2 rst = 1'b1;
    #1;
    exp_mode = 2'd0; exp_pause = 1'b0;
    n_checks++;
    if (mode !== 2'd0 || pause !== 1'b0 || led !== 6'h3F) begin
      n_errors++;
      $display("FAIL async_reset: mode=%0d pause=%b led=%h, expected 0 0 3f", mode, pause, led);
    end
    key = 2'b10;
    step(); step();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 7) exp_mode = exp_mode + 2'd1;
      sb.push_back(mk(6'h3F, 1'b1));
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 8) key = 2'b11;
      e = sb.pop_front(); n_checks++;
      if (mode !== e.mode || pause !== e.pause || led !== e.led) begin
        n_errors++;
        $display("FAIL held_through_reset step %0d: mode=%0d pause=%b led=%h, expected mode=%0d pause=%b led=%h",
                 i, mode, pause, led, e.mode, e.pause, e.led);
      end
    end
    repeat (10) step();
  endtask

  initial begin
    rst = 1'b1;
    key = 2'b11;
    test_reset();
    test_glitch();
    test_chase();
    test_breathe();
    test_pause();
    test_both_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
